fp_div_sched: RTL and testbench
===============================

FP_DIV_SCHED -- requirements
Module: fp_div_sched

Interface
REQ-001 The module SHALL have parameter TAG_W, default 4, setting the requester tag width in bits.
REQ-002 The module SHALL have parameter TIMEOUT, default 40, setting the BUSY-state watchdog limit in cycles.
REQ-003 The module SHALL have port clk_i, input, width 1: the single clock.
REQ-004 The module SHALL have port rst_ni, input, width 1: asynchronous, active-low reset.
REQ-005 The module SHALL have ports req0_valid_i and req1_valid_i, input, width 1 each: request pending.
REQ-006 The module SHALL have ports req0_a_i, req0_b_i, req1_a_i and req1_b_i, input, width 32 each: FP32 dividend and divisor.
REQ-007 The module SHALL have ports req0_tag_i and req1_tag_i, input, width TAG_W each: requester tag.
REQ-008 The module SHALL have ports req0_ready_o and req1_ready_o, output, width 1 each: request accepted this cycle.
REQ-009 The module SHALL have port flush_i, input, width 1: abort the in-flight operation.
REQ-010 The module SHALL have ports div_start_o and div_stop_o, output, width 1 each: divider start and stop.
REQ-011 The module SHALL have ports div_a_o and div_b_o, output, width 32 each: divider operands.
REQ-012 The module SHALL have ports div_ready_i and div_done_i, input, width 1 each: divider idle and divider write-cycle indications.
REQ-013 The module SHALL have port div_result_i, input, width 32: divider result register.
REQ-014 The module SHALL have ports rsp_valid_o and rsp_err_o, output, width 1 each; rsp_id_o, output, width 1; rsp_tag_o, output, width TAG_W; rsp_data_o, output, width 32; and rsp_ready_i, input, width 1.

Function
REQ-015 The FSM SHALL have states IDLE, ISSUE, BUSY, ABORT, CAPTURE and RESP.
REQ-016 In IDLE, when any reqN_valid_i=1 and div_ready_i=1, the block SHALL grant exactly one requester, pulse that requester's reqN_ready_o for one cycle, latch its a, b and tag, set rsp_id to N, and go to ISSUE.
REQ-017 Arbitration SHALL be round-robin: on simultaneous valid requests, the requester not granted last wins; the last-grant pointer resets to 1, so requester 0 wins first.
REQ-018 ISSUE SHALL assert div_start_o for exactly one cycle, then go to BUSY.
REQ-019 div_a_o and div_b_o SHALL hold the latched operands, stable from ISSUE through CAPTURE.
REQ-020 BUSY SHALL wait for div_done_i=1, then go to CAPTURE.
REQ-021 CAPTURE SHALL register div_result_i into rsp_data_o (sampled one cycle after div_done_i), then go to RESP.
REQ-022 RESP SHALL hold rsp_valid_o=1 with stable data until rsp_ready_i=1, then go to IDLE and update the last-grant pointer.
REQ-023 flush_i=1 in ISSUE or BUSY SHALL go to ABORT.
REQ-024 ABORT SHALL hold div_stop_o=1 until div_ready_i=1, then go to IDLE with no response; a div_done_i during ABORT SHALL be discarded.
REQ-025 flush_i=1 in CAPTURE or RESP SHALL drop the response and go to IDLE; flush_i=1 in IDLE SHALL have no effect.
REQ-026 When flush_i and rsp_ready_i are both 1 in RESP, flush_i SHALL win and rsp_valid_o SHALL fall with no handshake counted.
REQ-027 Minimum latency SHALL be accept at cycle 0, div_start_o at cycle 1, rsp_valid_o one cycle after CAPTURE.

Reset
REQ-028 While rst_ni=0, the FSM SHALL be IDLE and every output SHALL be 0; rsp_data_o, div_a_o and div_b_o SHALL be 32'h0.
REQ-029 Reset SHALL take effect asynchronously at any state, including mid-operation, with no divider handshake required.

Configuration
REQ-030 With FP_DIV_SCHED_TIMEOUT_EN defined, a cycle counter SHALL run in BUSY; on reaching TIMEOUT without div_done_i, the block SHALL go to ABORT and, once div_ready_i=1, go to RESP with rsp_err_o=1 and rsp_data_o=32'h7FC00000.
REQ-031 With FP_DIV_SCHED_TIMEOUT_EN undefined, there SHALL be no counter, rsp_err_o SHALL be tied 0, and BUSY SHALL wait indefinitely.

Verification
REQ-032 The bench SHALL drive req0 with a=32'h40C00000 (6.0), b=32'h40000000 (2.0), tag=3 and require rsp_data_o=32'h40400000, rsp_id_o=0, rsp_tag_o=3.
REQ-033 The bench SHALL hold both requesters valid for three operations and require the grant order 0, 1, 0.
REQ-034 The bench SHALL assert flush_i two cycles into BUSY and require div_stop_o held high until div_ready_i=1, no rsp_valid_o, and the next request served normally.
REQ-035 The bench SHALL hold rsp_ready_i=0 for five cycles in RESP and require rsp_valid_o and rsp_data_o stable, with no new grant.
REQ-036 The bench SHALL, with FP_DIV_SCHED_TIMEOUT_EN defined, hold div_done_i=0 and require an abort after 40 BUSY cycles, then rsp_err_o=1 and rsp_data_o=32'h7FC00000.
REQ-037 The bench SHALL pull rst_ni low during BUSY and require all outputs 0 immediately and the FSM in IDLE.

Source files
------------

// File: rtl/fp_div_sched.sv
// fp_div_sched: round-robin scheduler that shares one FP32 divider between two requesters.
// Define FP_DIV_SCHED_TIMEOUT_EN to add a BUSY watchdog that returns an error response (qNaN).
module fp_div_sched #(
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned TIMEOUT = 40
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req0_valid_i,
  input  logic [31:0]      req0_a_i,
  input  logic [31:0]      req0_b_i,
  input  logic [TAG_W-1:0] req0_tag_i,
  output logic             req0_ready_o,
  input  logic             req1_valid_i,
  input  logic [31:0]      req1_a_i,
  input  logic [31:0]      req1_b_i,
  input  logic [TAG_W-1:0] req1_tag_i,
  output logic             req1_ready_o,
  input  logic             flush_i,
  output logic             div_start_o,
  output logic             div_stop_o,
  output logic [31:0]      div_a_o,
  output logic [31:0]      div_b_o,
  input  logic             div_ready_i,
  input  logic             div_done_i,
  input  logic [31:0]      div_result_i,
  output logic             rsp_valid_o,
  output logic             rsp_err_o,
  output logic             rsp_id_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic [31:0]      rsp_data_o,
  input  logic             rsp_ready_i
);

  localparam int unsigned DATA_W = 32;
  localparam logic [DATA_W-1:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_BUSY,
    S_ABORT,
    S_CAPTURE,
    S_RESP
  } state_e;

  state_e              state_q, state_d;
  logic                last_q, last_d;
  logic                id_q, id_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                rdy0_q, rdy0_d;
  logic                rdy1_q, rdy1_d;
  logic                start_q, start_d;
  logic                stop_q, stop_d;
  logic                valid_q, valid_d;
  logic                any_req;
  logic                grant;

`ifdef FP_DIV_SCHED_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                to_q, to_d;
  logic                err_q, err_d;
  logic                timeout_hit;

  // Fires in the last permitted BUSY cycle without a completion.
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
`endif

  assign any_req = req0_valid_i | req1_valid_i;

  // Contention goes to the requester not served last; otherwise to whoever asks.
  always_comb begin
    if (req0_valid_i && req1_valid_i) begin
      grant = ~last_q;
    end else begin
      grant = req1_valid_i;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    tag_d   = tag_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    rdy0_d  = 1'b0;
    rdy1_d  = 1'b0;
`ifdef FP_DIV_SCHED_TIMEOUT_EN
    to_d    = to_q;
    err_d   = err_q;
    cnt_d   = '0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (any_req && div_ready_i) begin
          state_d = S_ISSUE;
          id_d    = grant;
          rdy0_d  = ~grant;
          rdy1_d  = grant;
          if (grant) begin
            a_d   = req1_a_i;
            b_d   = req1_b_i;
            tag_d = req1_tag_i;
          end else begin
            a_d   = req0_a_i;
            b_d   = req0_b_i;
            tag_d = req0_tag_i;
          end
        end
      end

      S_ISSUE: begin
        state_d = flush_i ? S_ABORT : S_BUSY;
      end

      S_BUSY: begin
        if (flush_i) begin
          state_d = S_ABORT;
        end else if (div_done_i) begin
          state_d = S_CAPTURE;
        end
`ifdef FP_DIV_SCHED_TIMEOUT_EN
        else if (timeout_hit) begin
          state_d = S_ABORT;
          to_d    = 1'b1;
        end
        cnt_d = cnt_q + CNT_W'(1);
`endif
      end

      // A late div_done_i here belongs to the abandoned operation and is ignored.
      S_ABORT: begin
        if (div_ready_i) begin
`ifdef FP_DIV_SCHED_TIMEOUT_EN
          if (to_q) begin
            state_d = S_RESP;
            data_d  = QNAN;
            err_d   = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
          to_d = 1'b0;
`else
          state_d = S_IDLE;
`endif
        end
      end

      S_CAPTURE: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          data_d  = div_result_i;
          state_d = S_RESP;
        end
      end

      // Flush beats a simultaneous handshake, so the grant pointer is left untouched.
      S_RESP: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else if (rsp_ready_i) begin
          state_d = S_IDLE;
          last_d  = id_q;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    start_d = (state_q == S_ISSUE) && (state_d == S_BUSY);
    stop_d  = (state_d == S_ABORT);
    valid_d = (state_d == S_RESP);
`ifdef FP_DIV_SCHED_TIMEOUT_EN
    if (state_d != S_RESP) begin
      err_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      tag_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      rdy0_q  <= 1'b0;
      rdy1_q  <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      tag_q   <= tag_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      rdy0_q  <= rdy0_d;
      rdy1_q  <= rdy1_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      valid_q <= valid_d;
    end
  end

`ifdef FP_DIV_SCHED_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
      err_q <= err_d;
    end
  end

  assign rsp_err_o = err_q;
`else
  assign rsp_err_o = 1'b0;
`endif

  assign req0_ready_o = rdy0_q;
  assign req1_ready_o = rdy1_q;
  assign div_start_o  = start_q;
  assign div_stop_o   = stop_q;
  assign div_a_o      = a_q;
  assign div_b_o      = b_q;
  assign rsp_valid_o  = valid_q;
  assign rsp_id_o     = id_q;
  assign rsp_tag_o    = tag_q;
  assign rsp_data_o   = data_q;

endmodule

// File: tb/tb_fp_div_sched.sv
// Directed bench for fp_div_sched with a small behavioural divider stub.
module tb_fp_div_sched;

  localparam int unsigned TAG_W   = 4;
  localparam int unsigned TIMEOUT = 40;

  logic             clk_i        = 1'b0;
  logic             rst_ni       = 1'b0;
  logic             req0_valid_i = 1'b0;
  logic [31:0]      req0_a_i     = '0;
  logic [31:0]      req0_b_i     = '0;
  logic [TAG_W-1:0] req0_tag_i   = '0;
  logic             req0_ready_o;
  logic             req1_valid_i = 1'b0;
  logic [31:0]      req1_a_i     = '0;
  logic [31:0]      req1_b_i     = '0;
  logic [TAG_W-1:0] req1_tag_i   = '0;
  logic             req1_ready_o;
  logic             flush_i      = 1'b0;
  logic             div_start_o;
  logic             div_stop_o;
  logic [31:0]      div_a_o;
  logic [31:0]      div_b_o;
  logic             div_ready_i  = 1'b1;
  logic             div_done_i   = 1'b0;
  logic [31:0]      div_result_i = '0;
  logic             rsp_valid_o;
  logic             rsp_err_o;
  logic             rsp_id_o;
  logic [TAG_W-1:0] rsp_tag_o;
  logic [31:0]      rsp_data_o;
  logic             rsp_ready_i  = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  bit hang    = 1'b0;

  fp_div_sched #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req0_valid_i (req0_valid_i),
    .req0_a_i     (req0_a_i),
    .req0_b_i     (req0_b_i),
    .req0_tag_i   (req0_tag_i),
    .req0_ready_o (req0_ready_o),
    .req1_valid_i (req1_valid_i),
    .req1_a_i     (req1_a_i),
    .req1_b_i     (req1_b_i),
    .req1_tag_i   (req1_tag_i),
    .req1_ready_o (req1_ready_o),
    .flush_i      (flush_i),
    .div_start_o  (div_start_o),
    .div_stop_o   (div_stop_o),
    .div_a_o      (div_a_o),
    .div_b_o      (div_b_o),
    .div_ready_i  (div_ready_i),
    .div_done_i   (div_done_i),
    .div_result_i (div_result_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_err_o    (rsp_err_o),
    .rsp_id_o     (rsp_id_o),
    .rsp_tag_o    (rsp_tag_o),
    .rsp_data_o   (rsp_data_o),
    .rsp_ready_i  (rsp_ready_i)
  );

  always #5 clk_i = ~clk_i;

  // Quotients for the operand pairs used below, worked out by hand.
  function automatic logic [31:0] quot(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h40C0_0000, 32'h4000_0000}: return 32'h4040_0000;
      {32'h4120_0000, 32'h4080_0000}: return 32'h4020_0000;
      {32'h3F80_0000, 32'h4000_0000}: return 32'h3F00_0000;
      default:                        return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Divider stub: 4-cycle latency, stop takes 2 cycles and races a stray done pulse.
  logic        m_busy = 1'b0;
  logic        m_stop = 1'b0;
  int          m_cnt  = 0;
  logic [31:0] m_a    = '0;
  logic [31:0] m_b    = '0;

  always @(posedge clk_i) begin
    div_done_i <= 1'b0;
    if (!rst_ni) begin
      div_ready_i <= 1'b1;
      m_busy      <= 1'b0;
      m_stop      <= 1'b0;
      m_cnt       <= 0;
    end else if (m_stop) begin
      if (m_cnt <= 1) begin
        m_stop      <= 1'b0;
        div_ready_i <= 1'b1;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else if (m_busy && div_stop_o) begin
      m_busy       <= 1'b0;
      m_stop       <= 1'b1;
      m_cnt        <= 2;
      div_done_i   <= 1'b1;
      div_result_i <= 32'h0BAD_0BAD;
    end else if (m_busy) begin
      if (!hang) begin
        if (m_cnt <= 1) begin
          div_done_i   <= 1'b1;
          div_result_i <= quot(m_a, m_b);
          div_ready_i  <= 1'b1;
          m_busy       <= 1'b0;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end else if (div_start_o && div_ready_i) begin
      m_busy      <= 1'b1;
      m_cnt       <= 4;
      div_ready_i <= 1'b0;
      m_a         <= div_a_o;
      m_b         <= div_b_o;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(output int id, output int cyc);
    id  = -1;
    cyc = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk_i);
      if (req0_ready_o || req1_ready_o) begin
        id  = (req0_ready_o && req1_ready_o) ? 2 : (req1_ready_o ? 1 : 0);
        cyc = i;
        break;
      end
    end
  endtask

  task automatic check_issue(input string tag, input logic [31:0] ea, input logic [31:0] eb);
    @(negedge clk_i);
    check({tag, "_start"}, 64'(div_start_o), 64'd1);
    check({tag, "_opa"}, 64'(div_a_o), 64'(ea));
    check({tag, "_opb"}, 64'(div_b_o), 64'(eb));
    @(negedge clk_i);
    check({tag, "_start_pulse"}, 64'(div_start_o), 64'd0);
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 80; i++) begin
      if (rsp_valid_o) break;
      @(negedge clk_i);
    end
  endtask

  task automatic finish_rsp(input string tag, input logic [31:0] ed, input logic eid,
                            input logic [TAG_W-1:0] etag, input logic eerr);
    wait_rsp();
    check({tag, "_valid"}, 64'(rsp_valid_o), 64'd1);
    check({tag, "_data"}, 64'(rsp_data_o), 64'(ed));
    check({tag, "_id"}, 64'(rsp_id_o), 64'(eid));
    check({tag, "_tag"}, 64'(rsp_tag_o), 64'(etag));
    check({tag, "_err"}, 64'(rsp_err_o), 64'(eerr));
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    check({tag, "_drop"}, 64'(rsp_valid_o), 64'd0);
  endtask

  task automatic set_req0(input logic v);
    req0_a_i = 32'h40C0_0000; req0_b_i = 32'h4000_0000; req0_tag_i = 4'd3; req0_valid_i = v;
  endtask

  task automatic set_req1(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t,
                          input logic v);
    req1_a_i = a; req1_b_i = b; req1_tag_i = t; req1_valid_i = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    int id, cyc, stop_cyc;
    bit saw, last_rdy, stable, nogrant;
    int rr_exp [3];
    rr_exp = '{0, 1, 0};

    // Reset values
    repeat (3) @(negedge clk_i);
    check("reset_ctrl", 64'({req0_ready_o, req1_ready_o, div_start_o, div_stop_o,
                             rsp_valid_o, rsp_err_o, rsp_id_o, rsp_tag_o}), 64'd0);
    check("reset_div_a", 64'(div_a_o), 64'd0);
    check("reset_div_b", 64'(div_b_o), 64'd0);
    check("reset_data", 64'(rsp_data_o), 64'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Round robin with both requesters held valid: 0, 1, 0
    set_req0(1'b1);
    set_req1(32'h4120_0000, 32'h4080_0000, 4'd9, 1'b1);
    for (int k = 0; k < 3; k++) begin
      wait_ready(id, cyc);
      check($sformatf("rr_grant%0d", k), 64'(id), 64'(rr_exp[k]));
      if (k == 2) begin
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
      end
      if (rr_exp[k] == 0) finish_rsp($sformatf("rr%0d", k), 32'h4040_0000, 1'b0, 4'd3, 1'b0);
      else                finish_rsp($sformatf("rr%0d", k), 32'h4020_0000, 1'b1, 4'd9, 1'b0);
    end

    // 6.0 / 2.0 from requester 0, with a flush in IDLE that must be ignored
    set_req0(1'b1);
    flush_i = 1'b1;
    wait_ready(id, cyc);
    flush_i = 1'b0;
    req0_valid_i = 1'b0;
    check("basic_grant", 64'(id), 64'd0);
    check("basic_accept_lat", 64'(cyc), 64'd1);
    check_issue("basic", 32'h40C0_0000, 32'h4000_0000);
    finish_rsp("basic", 32'h4040_0000, 1'b0, 4'd3, 1'b0);

    // Response stalled for five cycles while requester 0 waits
    set_req1(32'h3F80_0000, 32'h4000_0000, 4'd6, 1'b1);
    wait_ready(id, cyc);
    check("stall_grant", 64'(id), 64'd1);
    req1_valid_i = 1'b0;
    set_req0(1'b1);
    wait_rsp();
    check("stall_data0", 64'(rsp_data_o), 64'h3F00_0000);
    stable  = 1'b1;
    nogrant = 1'b1;
    repeat (5) begin
      @(negedge clk_i);
      if (!rsp_valid_o || rsp_data_o !== 32'h3F00_0000) stable = 1'b0;
      if (req0_ready_o || req1_ready_o) nogrant = 1'b0;
    end
    check("stall_stable", 64'(stable), 64'd1);
    check("stall_no_grant", 64'(nogrant), 64'd1);
    finish_rsp("stall", 32'h3F00_0000, 1'b1, 4'd6, 1'b0);
    wait_ready(id, cyc);
    req0_valid_i = 1'b0;
    check("stall_next_grant", 64'(id), 64'd0);
    finish_rsp("stall_next", 32'h4040_0000, 1'b0, 4'd3, 1'b0);

    // Flush two cycles into BUSY
    set_req0(1'b1);
    wait_ready(id, cyc);
    req0_valid_i = 1'b0;
    check("flush_grant", 64'(id), 64'd0);
    check_issue("flush", 32'h40C0_0000, 32'h4000_0000);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i  = 1'b0;
    stop_cyc = 0;
    last_rdy = 1'b0;
    saw      = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!div_stop_o) break;
      stop_cyc++;
      last_rdy = div_ready_i;
      saw |= rsp_valid_o;
      @(negedge clk_i);
    end
    repeat (8) begin
      saw |= rsp_valid_o;
      @(negedge clk_i);
    end
    check("flush_stop_cycles", 64'(stop_cyc), 64'd4);
    check("flush_stop_until_ready", 64'(last_rdy), 64'd1);
    check("flush_no_rsp", 64'(saw), 64'd0);
    set_req1(32'h4120_0000, 32'h4080_0000, 4'd5, 1'b1);
    wait_ready(id, cyc);
    req1_valid_i = 1'b0;
    check("after_flush_grant", 64'(id), 64'd1);
    check_issue("after_flush", 32'h4120_0000, 32'h4080_0000);
    finish_rsp("after_flush", 32'h4020_0000, 1'b1, 4'd5, 1'b0);

    // Flush and rsp_ready together in RESP: flush wins, pointer stays on requester 1
    set_req0(1'b1);
    wait_ready(id, cyc);
    req0_valid_i = 1'b0;
    wait_rsp();
    check("flush_rsp_valid", 64'(rsp_valid_o), 64'd1);
    flush_i     = 1'b1;
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    flush_i     = 1'b0;
    rsp_ready_i = 1'b0;
    check("flush_rsp_drop", 64'(rsp_valid_o), 64'd0);
    set_req0(1'b1);
    set_req1(32'h4120_0000, 32'h4080_0000, 4'd5, 1'b1);
    wait_ready(id, cyc);
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    check("flush_rsp_no_handshake", 64'(id), 64'd0);
    finish_rsp("flush_rsp_next", 32'h4040_0000, 1'b0, 4'd3, 1'b0);

    // Divider that never completes
    hang = 1'b1;
    set_req0(1'b1);
    wait_ready(id, cyc);
    req0_valid_i = 1'b0;
    check_issue("hang", 32'h40C0_0000, 32'h4000_0000);
`ifdef FP_DIV_SCHED_TIMEOUT_EN
    stop_cyc = 2;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (div_stop_o) break;
      stop_cyc++;
    end
    check("timeout_busy_cycles", 64'(stop_cyc), 64'd40);
    finish_rsp("timeout", 32'h7FC0_0000, 1'b0, 4'd3, 1'b1);
    hang = 1'b0;
`else
    saw = 1'b0;
    repeat (60) begin
      @(negedge clk_i);
      saw |= div_stop_o | rsp_valid_o;
    end
    check("hang_waits", 64'(saw), 64'd0);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!div_stop_o) break;
      @(negedge clk_i);
    end
    check("hang_flush_recovers", 64'(div_stop_o), 64'd0);
    hang = 1'b0;
`endif

    // Asynchronous reset in the middle of BUSY
    set_req1(32'h4120_0000, 32'h4080_0000, 4'd5, 1'b1);
    wait_ready(id, cyc);
    req1_valid_i = 1'b0;
    check("rst_grant", 64'(id), 64'd1);
    check_issue("rst", 32'h4120_0000, 32'h4080_0000);
    #2 rst_ni = 1'b0;
    #1;
    check("rst_ctrl", 64'({req0_ready_o, req1_ready_o, div_start_o, div_stop_o,
                           rsp_valid_o, rsp_err_o, rsp_id_o, rsp_tag_o}), 64'd0);
    check("rst_div_a", 64'(div_a_o), 64'd0);
    check("rst_div_b", 64'(div_b_o), 64'd0);
    check("rst_data", 64'(rsp_data_o), 64'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    set_req0(1'b1);
    set_req1(32'h4120_0000, 32'h4080_0000, 4'd5, 1'b1);
    wait_ready(id, cyc);
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    check("post_rst_grant", 64'(id), 64'd0);
    check("post_rst_idle", 64'(cyc), 64'd1);
    finish_rsp("post_rst", 32'h4040_0000, 1'b0, 4'd3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
